// File: rtl/fob_pkg.sv
// Shared definitions for the OTP key-fob controller: state encoding, code width
// and default timing parameters.
package fob_pkg;

  localparam int CODE_W           = 16;
  localparam int DEF_SHOW_TICKS   = 2500;
  localparam int DEF_HASH_TIMEOUT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_SHOW    = 2'd2,
    ST_REFRESH = 2'd3
  } fob_state_e;

endpackage

// File: rtl/fob_tick_timer.sv
// Tick counter with synchronous clear that saturates at LIMIT-1; tc_o flags the
// terminal count so the owner can act on the tick that would pass it.
module fob_tick_timer #(
  parameter int CNT_W = 12,
  parameter int LIMIT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != TERM)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/otp_fob_sequencer.sv
// Key-fob sequencer: fetches a one-time code from the hasher on a button press,
// shows it for a fixed window and refreshes it when an epoch boundary passes.
module otp_fob_sequencer
  import fob_pkg::*;
#(
  parameter int SHOW_TICKS   = DEF_SHOW_TICKS,
  parameter int HASH_TIMEOUT = DEF_HASH_TIMEOUT,
  parameter int CNT_W        = 12
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              tick_500hz,
  input  logic              epoch_tick,
  input  logic              button_press,
  input  logic              hash_ack,
  input  logic [CODE_W-1:0] hash_value,
  output logic              hash_req,
  output logic [CODE_W-1:0] code_out,
  output logic              display_en,
  output logic              hash_err,
  output logic [1:0]        state_dbg
);

  // Handshake: hash_req is a level held until hash_ack is sampled while it is high;
  // an ack seen while hash_req is low, or outside FETCH/REFRESH, is ignored.
  fob_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              disp_q, disp_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;
  logic              show_clr, show_tc, hash_tc;
  logic              ack_ok, hash_to, show_exp;

  assign ack_ok   = hash_ack && req_q && ((state_q == ST_FETCH) || (state_q == ST_REFRESH));
  assign hash_to  = req_q && tick_500hz && hash_tc;
  assign show_exp = tick_500hz && show_tc;

  fob_tick_timer #(.CNT_W(CNT_W), .LIMIT(SHOW_TICKS)) u_show_timer (
    .clk_i  (sysclk),
    .rst_i  (rst),
    .clr_i  (show_clr),
    .tick_i (tick_500hz && ((state_q == ST_SHOW) || (state_q == ST_REFRESH))),
    .tc_o   (show_tc)
  );

  // The timeout count only runs while a request is outstanding.
  fob_tick_timer #(.CNT_W(CNT_W), .LIMIT(HASH_TIMEOUT)) u_hash_timer (
    .clk_i  (sysclk),
    .rst_i  (rst),
    .clr_i  (!req_q || ack_ok),
    .tick_i (tick_500hz),
    .tc_o   (hash_tc)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    code_d   = code_q;
    err_d    = err_q;
    pend_d   = pend_q;
    show_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (button_press) begin
          state_d  = ST_FETCH;
          req_d    = 1'b1;
          err_d    = 1'b0;
          pend_d   = 1'b0;
          show_clr = 1'b1;
        end
      end
      ST_FETCH: begin
        if (epoch_tick) pend_d = 1'b1;
        if (!req_q) begin
          req_d = 1'b1;
        end else if (ack_ok) begin
          code_d   = hash_value;
          req_d    = 1'b0;
          show_clr = 1'b1;
          pend_d   = 1'b0;
          if (!pend_q) state_d = ST_SHOW;
        end else if (hash_to) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          pend_d  = 1'b0;
        end
      end
      ST_SHOW: begin
        if (show_exp) begin
          state_d = ST_IDLE;
        end else if (epoch_tick) begin
          state_d = ST_REFRESH;
          req_d   = 1'b1;
        end else if (button_press) begin
          show_clr = 1'b1;
        end
      end
      ST_REFRESH: begin
        if (ack_ok) begin
          code_d  = hash_value;
          req_d   = 1'b0;
          state_d = show_tc ? ST_IDLE : ST_SHOW;
        end else if (hash_to) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_SHOW;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    disp_d = (state_d == ST_SHOW) || (state_d == ST_REFRESH);
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      code_q  <= '0;
      disp_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      code_q  <= code_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign hash_req   = req_q;
  assign code_out   = code_q;
  assign display_en = disp_q;
  assign hash_err   = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_otp_fob_sequencer.sv
// Self-checking bench for otp_fob_sequencer with a short display window and
// timeout; accepted codes are tracked through an expected-code queue.
module tb_otp_fob_sequencer;

  localparam int W = 16;

  logic         sysclk = 1'b0;
  logic         rst = 1'b1;
  logic         tick_500hz = 1'b0;
  logic         epoch_tick = 1'b0;
  logic         button_press = 1'b0;
  logic         hash_ack = 1'b0;
  logic [W-1:0] hash_value = '0;
  logic         hash_req;
  logic [W-1:0] code_out;
  logic         display_en;
  logic         hash_err;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_code;

  otp_fob_sequencer #(.SHOW_TICKS(4), .HASH_TIMEOUT(3), .CNT_W(12)) dut (
    .sysclk       (sysclk),
    .rst          (rst),
    .tick_500hz   (tick_500hz),
    .epoch_tick   (epoch_tick),
    .button_press (button_press),
    .hash_ack     (hash_ack),
    .hash_value   (hash_value),
    .hash_req     (hash_req),
    .code_out     (code_out),
    .display_en   (display_en),
    .hash_err     (hash_err),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_press();
    button_press = 1'b1; cyc(); button_press = 1'b0;
  endtask

  task automatic do_tick();
    tick_500hz = 1'b1; cyc(); tick_500hz = 1'b0;
  endtask

  task automatic do_epoch();
    epoch_tick = 1'b1; cyc(); epoch_tick = 1'b0;
  endtask

  task automatic do_ack(input logic [W-1:0] v);
    exp_q.push_back(v);
    hash_value = v; hash_ack = 1'b1; cyc(); hash_ack = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  // scoreboard: every change of code_out must match the next accepted ack value
  always @(negedge sysclk) begin
    if (rst) begin
      prev_code = code_out;
    end else if (code_out !== prev_code) begin
      if (exp_q.size() == 0) check("code_unexp", code_out, prev_code);
      else check("code_sb", code_out, exp_q.pop_front());
      prev_code = code_out;
    end
  end

  initial begin
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_state", state_dbg, 0);
    check("rst_req", hash_req, 0);
    check("rst_code", code_out, 0);
    check("rst_disp", display_en, 0);
    check("rst_err", hash_err, 0);
    rst = 1'b0;
    cyc();

    // basic fetch, show window, expiry
    do_press();
    check("s1_state_fetch", state_dbg, 1);
    check("s1_req", hash_req, 1);
    check("s1_disp_off", display_en, 0);
    cyc();
    do_ack(16'h1A2B);
    check("s1_state_show", state_dbg, 2);
    check("s1_disp_on", display_en, 1);
    check("s1_req_low", hash_req, 0);
    ticks(3);
    check("s1_show_hold", state_dbg, 2);
    do_tick();
    check("s1_expire_state", state_dbg, 0);
    check("s1_expire_disp", display_en, 0);
    check("s1_code_kept", code_out, 16'h1A2B);
    hash_value = 16'hBEEF; hash_ack = 1'b1; cyc(); hash_ack = 1'b0;
    check("idle_ack_state", state_dbg, 0);
    check("idle_ack_req", hash_req, 0);

    // hasher timeout, then recovery
    do_press();
    check("s2_req", hash_req, 1);
    check("s2_err_clr", hash_err, 0);
    do_tick();
    do_press();
    check("s2_press_ignored", state_dbg, 1);
    do_tick();
    check("s2_not_yet", hash_req, 1);
    do_tick();
    check("s2_to_req", hash_req, 0);
    check("s2_to_err", hash_err, 1);
    check("s2_to_state", state_dbg, 0);
    do_press();
    check("s2_err_cleared", hash_err, 0);
    check("s2_req_again", hash_req, 1);
    do_ack(16'h0C0D);
    check("s2_show", state_dbg, 2);

    // epoch refresh while showing
    do_tick();
    do_epoch();
    check("s3_refresh", state_dbg, 3);
    check("s3_req", hash_req, 1);
    check("s3_disp", display_en, 1);
    cyc();
    check("s3_disp_wait", display_en, 1);
    do_ack(16'h5555);
    check("s3_back_show", state_dbg, 2);
    check("s3_disp_after", display_en, 1);
    check("s3_req_low", hash_req, 0);
    do_tick();
    do_press();
    ticks(3);
    check("s3_press_extend", state_dbg, 2);
    do_tick();
    check("s3_expire", state_dbg, 0);

    // epoch during fetch forces a second request
    do_press();
    do_epoch();
    do_ack(16'h0001);
    check("s4_stay_fetch", state_dbg, 1);
    check("s4_req_drop", hash_req, 0);
    cyc();
    check("s4_req_back", hash_req, 1);
    check("s4_disp_off", display_en, 0);
    do_ack(16'h0002);
    check("s4_show", state_dbg, 2);
    check("s4_disp_on", display_en, 1);

    // expiry beats epoch in the same cycle
    ticks(3);
    check("s5_still_show", state_dbg, 2);
    tick_500hz = 1'b1; epoch_tick = 1'b1; cyc(); tick_500hz = 1'b0; epoch_tick = 1'b0;
    check("s5_idle", state_dbg, 0);
    check("s5_disp", display_en, 0);
    check("s5_req", hash_req, 0);
    cyc();
    check("s5_req_stays", hash_req, 0);

    // press and epoch together in IDLE: one request only
    button_press = 1'b1; epoch_tick = 1'b1; cyc(); button_press = 1'b0; epoch_tick = 1'b0;
    check("pe_fetch", state_dbg, 1);
    check("pe_req", hash_req, 1);
    do_ack(16'h7777);
    check("pe_single_req", state_dbg, 2);

    // refresh timeout keeps old code and flags error
    do_epoch();
    check("rt_refresh", state_dbg, 3);
    ticks(3);
    check("rt_state", state_dbg, 2);
    check("rt_err", hash_err, 1);
    check("rt_req", hash_req, 0);
    check("rt_disp", display_en, 1);
    check("rt_code", code_out, 16'h7777);

    // asynchronous reset mid-refresh
    do_press();
    do_epoch();
    check("ar_refresh", state_dbg, 3);
    check("ar_req_pre", hash_req, 1);
    check("ar_err_pre", hash_err, 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_req", hash_req, 0);
    check("ar_disp", display_en, 0);
    check("ar_code", code_out, 0);
    check("ar_err", hash_err, 0);
    check("ar_state", state_dbg, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // ack in REFRESH after the window saturated ends the display
    do_press();
    do_ack(16'h1111);
    check("sat_show", state_dbg, 2);
    ticks(2);
    do_epoch();
    check("sat_refresh", state_dbg, 3);
    do_tick();
    do_ack(16'h2222);
    check("sat_idle", state_dbg, 0);
    check("sat_disp", display_en, 0);

    cyc();
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
